// File: rtl/quantum_preempt_ctrl_if.sv
// Context-save / vector handshake between the quantum controller and the
// register file / program counter.
interface quantum_preempt_ctrl_if #(
    parameter int AW = 12
);
    logic          stored;     // context-save request
    logic          stored_ok;  // register file: context saved
    logic          interrupt;  // one-cycle vector-to-OS pulse
    logic [AW-1:0] saved_pc;   // resume address of the preempted stream

    modport master (
        output stored,
        output interrupt,
        output saved_pc,
        input  stored_ok
    );

    modport slave (
        input  stored,
        input  interrupt,
        input  saved_pc,
        output stored_ok
    );
endinterface

// File: rtl/quantum_preempt_ctrl.sv
// Time-slice preemption controller: counts retired user instructions against
// a programmable quantum, then runs the context-save handshake and pulses
// interrupt so the program counter vectors to the OS scheduler.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | no user slice running; q_remaining held at 0
//   S_COUNT  | user slice running; each counted retire decrements the slice
//   S_SAVE   | slice expired; raise stored next edge, arm ack timer
//   S_WAIT   | stored high, waiting for stored_ok or timer terminal count
//   S_SWITCH | one-cycle interrupt pulse, bump preemption count
module quantum_preempt_ctrl #(
    parameter int QW          = 8,
    parameter int DEF_QUANTUM = 20,
    parameter int AW          = 12,
    parameter int ACK_TMO     = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,        // asynchronous, active-low
    input  logic          i_proc_mode,
    input  logic          i_retire,
    input  logic          i_hlt,
    input  logic          i_q_load,
    input  logic [QW-1:0] i_q_val,
    input  logic [AW-1:0] i_pc_in,
    quantum_preempt_ctrl_if.master bus,
    output logic [QW-1:0] o_q_remaining,
    output logic          o_ack_err,
    output logic [7:0]    o_preempt_cnt
);

    localparam int TW = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO);
    localparam logic [QW-1:0] DEF_Q    = QW'(DEF_QUANTUM);
    localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_SAVE,
        S_WAIT,
        S_SWITCH
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_quantum;
    logic [QW-1:0] r_q_rem;
    logic [TW-1:0] r_tmo;
    logic          r_timed_out;
    logic          r_stored;
    logic          r_interrupt;
    logic [AW-1:0] r_saved_pc;
    logic          r_ack_err;
    logic [7:0]    r_cnt;

    logic          w_count_evt;

    assign w_count_evt = i_retire & ~i_hlt;

    // Quantum register; only sampled when a slice starts, so a write lands
    // on the next slice rather than the running one.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_quantum <= DEF_Q;
        end else if (i_q_load) begin
            r_quantum <= (i_q_val == '0) ? DEF_Q : i_q_val;
        end
    end

    // Slice FSM with registered handshake outputs and ack down-counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_q_rem     <= '0;
            r_tmo       <= '0;
            r_timed_out <= 1'b0;
            r_stored    <= 1'b0;
            r_interrupt <= 1'b0;
            r_saved_pc  <= '0;
            r_ack_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_interrupt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_proc_mode) begin
                        r_q_rem <= r_quantum;
                        r_state <= S_COUNT;
                    end else begin
                        r_q_rem <= '0;
                    end
                end
                S_COUNT: begin
                    // Leaving user mode beats a same-cycle expiry: no save.
                    if (!i_proc_mode) begin
                        r_q_rem <= '0;
                        r_state <= S_IDLE;
                    end else if (w_count_evt) begin
                        if (r_q_rem == QW'(1)) begin
                            r_q_rem    <= '0;
                            r_saved_pc <= i_pc_in + AW'(1);
                            r_state    <= S_SAVE;
                        end else begin
                            r_q_rem <= r_q_rem - QW'(1);
                        end
                    end
                end
                S_SAVE: begin
                    r_stored    <= 1'b1;
                    r_tmo       <= TMO_LOAD;
                    r_timed_out <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // An ack on the terminal-count cycle still counts as an ack.
                    if (bus.stored_ok) begin
                        r_stored <= 1'b0;
                        r_state  <= S_SWITCH;
                    end else if (r_tmo == '0) begin
                        r_stored    <= 1'b0;
                        r_ack_err   <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_state     <= S_SWITCH;
                    end else begin
                        r_tmo <= r_tmo - TW'(1);
                    end
                end
                S_SWITCH: begin
                    r_interrupt <= 1'b1;
                    if (!r_timed_out && (r_cnt != 8'hFF)) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stored    = r_stored;
    assign bus.interrupt = r_interrupt;
    assign bus.saved_pc  = r_saved_pc;
    assign o_q_remaining = r_q_rem;
    assign o_ack_err     = r_ack_err;
    assign o_preempt_cnt = r_cnt;

endmodule

// File: tb/tb_quantum_preempt_ctrl.sv
// Randomized bench for quantum_preempt_ctrl. The reference is slice-level:
// a slice of length Q ends after exactly Q counted retires, the save
// handshake lasts as long as the ack is withheld (capped at ACK_TMO), and
// completed preemptions are tallied with saturation.
module tb_quantum_preempt_ctrl;
    localparam int QW      = 8;
    localparam int AW      = 12;
    localparam int DEF_Q   = 20;
    localparam int ACK_TMO = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          proc_mode;
    logic          retire;
    logic          hlt;
    logic          q_load;
    logic [QW-1:0] q_val;
    logic [AW-1:0] pc_in;
    logic [QW-1:0] q_rem;
    logic          ack_err;
    logic [7:0]    pcnt;

    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_quantum = DEF_Q;
    int   exp_cnt     = 0;
    logic exp_err     = 1'b0;

    quantum_preempt_ctrl_if #(.AW(AW)) bus ();

    quantum_preempt_ctrl #(
        .QW(QW), .DEF_QUANTUM(DEF_Q), .AW(AW), .ACK_TMO(ACK_TMO)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset_n),
        .i_proc_mode  (proc_mode),
        .i_retire     (retire),
        .i_hlt        (hlt),
        .i_q_load     (q_load),
        .i_q_val      (q_val),
        .i_pc_in      (pc_in),
        .bus          (bus),
        .o_q_remaining(q_rem),
        .o_ack_err    (ack_err),
        .o_preempt_cnt(pcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_quantum(input int v);
        q_load = 1'b1;
        q_val  = QW'(v);
        step();
        q_load = 1'b0;
        exp_quantum = (v == 0) ? DEF_Q : v;
    endtask

    // One full slice: start, random retire/hlt traffic until expiry, then the
    // save handshake (acked after ack_delay cycles of stored, or left to time
    // out), the interrupt pulse and the return to idle.
    task automatic run_slice(input int pc_last, input bit do_ack,
                             input int ack_delay, input int load_val);
        int            q;
        int            left;
        int            guard;
        int            hi;
        bit            cnt_evt;
        logic [AW-1:0] exp_pc;
        q      = exp_quantum;
        exp_pc = '0;
        proc_mode = 1'b1;
        step();
        vectors++;
        if (q_rem !== QW'(q)) begin
            miscompares++;
            $display("FAIL slice_start: q_remaining got %0d want %0d", q_rem, q);
        end
        left  = q;
        guard = 0;
        while (left > 0 && guard < 2000) begin
            retire        = 1'($urandom_range(0, 1));
            hlt           = ($urandom_range(0, 3) == 0);
            pc_in         = AW'($urandom);
            bus.stored_ok = 1'($urandom_range(0, 1));
            if (guard == 0 && load_val >= 0) begin
                q_load      = 1'b1;
                q_val       = QW'(load_val);
                exp_quantum = (load_val == 0) ? DEF_Q : load_val;
            end
            cnt_evt = retire && !hlt;
            if (cnt_evt && left == 1) begin
                if (pc_last >= 0) pc_in = AW'(pc_last);
                exp_pc = pc_in + AW'(1);
            end
            step();
            retire = 1'b0; hlt = 1'b0; q_load = 1'b0; bus.stored_ok = 1'b0;
            if (cnt_evt) left--;
            vectors++;
            if (q_rem !== QW'(left) || bus.stored !== 1'b0) begin
                miscompares++;
                $display("FAIL count: q_remaining/stored got %0d/%0b want %0d/0",
                         q_rem, bus.stored, left);
            end
            guard++;
        end
        if (left > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL slice_budget: %0d retires left after %0d cycles", left, guard);
        end
        proc_mode = 1'b0;
        step();
        vectors++;
        if (bus.stored !== 1'b1 || bus.interrupt !== 1'b0) begin
            miscompares++;
            $display("FAIL stored_latency: stored/interrupt got %0b/%0b want 1/0",
                     bus.stored, bus.interrupt);
        end
        vectors++;
        if (bus.saved_pc !== exp_pc) begin
            miscompares++;
            $display("FAIL saved_pc: got %h want %h", bus.saved_pc, exp_pc);
        end
        hi = 1;
        if (do_ack) begin
            for (int i = 1; i < ack_delay; i++) begin
                step();
                vectors++;
                if (bus.stored !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stored_hold: got %0b want 1 at wait cycle %0d", bus.stored, i);
                end
            end
            bus.stored_ok = 1'b1;
            step();
            bus.stored_ok = 1'b0;
            vectors++;
            if (bus.stored !== 1'b0) begin
                miscompares++;
                $display("FAIL stored_drop: got %0b want 0", bus.stored);
            end
            if (exp_cnt < 255) exp_cnt++;
        end else begin
            guard = 0;
            do begin
                step();
                guard++;
                if (bus.stored === 1'b1) hi++;
            end while (bus.stored === 1'b1 && guard < 40);
            vectors++;
            if (hi != ACK_TMO) begin
                miscompares++;
                $display("FAIL timeout_len: stored high %0d cycles want %0d", hi, ACK_TMO);
            end
            exp_err = 1'b1;
        end
        vectors++;
        if (bus.interrupt !== 1'b0 || ack_err !== exp_err) begin
            miscompares++;
            $display("FAIL pre_switch: interrupt/ack_err got %0b/%0b want 0/%0b",
                     bus.interrupt, ack_err, exp_err);
        end
        step();
        vectors++;
        if (bus.interrupt !== 1'b1 || pcnt !== 8'(exp_cnt)) begin
            miscompares++;
            $display("FAIL switch: interrupt/preempt_cnt got %0b/%0d want 1/%0d",
                     bus.interrupt, pcnt, exp_cnt);
        end
        step();
        vectors++;
        if (bus.interrupt !== 1'b0 || q_rem !== '0 || bus.stored !== 1'b0) begin
            miscompares++;
            $display("FAIL post_switch: interrupt/q_remaining/stored got %0b/%0d/%0b want 0/0/0",
                     bus.interrupt, q_rem, bus.stored);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; proc_mode = 1'b0; retire = 1'b0; hlt = 1'b0;
        q_load = 1'b0; q_val = '0; pc_in = '0; bus.stored_ok = 1'b0;
        #12;
        vectors++;
        if (bus.stored !== 1'b0 || bus.interrupt !== 1'b0 || bus.saved_pc !== '0 ||
            q_rem !== '0 || ack_err !== 1'b0 || pcnt !== '0) begin
            miscompares++;
            $display("FAIL reset_values: stored=%0b int=%0b pc=%h qrem=%0d err=%0b cnt=%0d want all 0",
                     bus.stored, bus.interrupt, bus.saved_pc, q_rem, ack_err, pcnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        vectors++;
        if (q_rem !== '0) begin
            miscompares++;
            $display("FAIL idle_hold: q_remaining got %0d want 0", q_rem);
        end
    endtask

    task automatic test_basic;
        run_slice(-1, 1'b1, 3, -1);
    endtask

    task automatic test_qload;
        load_quantum(0);
        run_slice(-1, 1'b1, 2, -1);
        run_slice(-1, 1'b1, 1, 3);
        run_slice(-1, 1'b1, 4, -1);
    endtask

    task automatic test_hlt;
        load_quantum(5);
        proc_mode = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            retire = 1'b1; hlt = 1'b1;
            step();
            retire = 1'b0;
            if (i % 2 == 0) step();
            vectors++;
            if (q_rem !== QW'(5) || bus.stored !== 1'b0) begin
                miscompares++;
                $display("FAIL hlt_freeze: q_remaining/stored got %0d/%0b want 5/0", q_rem, bus.stored);
            end
        end
        hlt = 1'b0; proc_mode = 1'b0;
        step();
        vectors++;
        if (q_rem !== '0) begin
            miscompares++;
            $display("FAIL hlt_exit: q_remaining got %0d want 0", q_rem);
        end
    endtask

    task automatic test_abort;
        int left;
        left = exp_quantum;
        proc_mode = 1'b1;
        step();
        while (left > 1) begin
            retire = 1'b1;
            step();
            retire = 1'b0;
            left--;
            vectors++;
            if (q_rem !== QW'(left)) begin
                miscompares++;
                $display("FAIL abort_count: q_remaining got %0d want %0d", q_rem, left);
            end
        end
        retire = 1'b1; proc_mode = 1'b0;
        step();
        retire = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.stored !== 1'b0 || bus.interrupt !== 1'b0 || q_rem !== '0) begin
                miscompares++;
                $display("FAIL abort_nosave: stored/interrupt/q_remaining got %0b/%0b/%0d want 0/0/0",
                         bus.stored, bus.interrupt, q_rem);
            end
            step();
        end
        vectors++;
        if (pcnt !== 8'(exp_cnt)) begin
            miscompares++;
            $display("FAIL abort_cnt: preempt_cnt got %0d want %0d", pcnt, exp_cnt);
        end
    endtask

    task automatic test_wrap;
        run_slice(12'hFFF, 1'b1, 2, -1);
    endtask

    task automatic test_timeout;
        run_slice(-1, 1'b0, 0, -1);
        run_slice(-1, 1'b1, 5, -1);
    endtask

    task automatic test_reset_mid;
        proc_mode = 1'b1;
        step();
        retire = 1'b1;
        repeat (exp_quantum) step();
        retire = 1'b0; proc_mode = 1'b0;
        step();
        step();
        step();
        vectors++;
        if (bus.stored !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_wait: stored got %0b want 1", bus.stored);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.stored !== 1'b0 || bus.interrupt !== 1'b0 || q_rem !== '0 ||
            ack_err !== 1'b0 || pcnt !== '0 || bus.saved_pc !== '0) begin
            miscompares++;
            $display("FAIL async_reset: stored=%0b int=%0b qrem=%0d err=%0b cnt=%0d pc=%h want all 0",
                     bus.stored, bus.interrupt, q_rem, ack_err, pcnt, bus.saved_pc);
        end
        exp_cnt = 0; exp_err = 1'b0; exp_quantum = DEF_Q;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        proc_mode = 1'b1;
        step();
        vectors++;
        if (q_rem !== QW'(DEF_Q) || bus.stored !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: q_remaining/stored got %0d/%0b want %0d/0", q_rem, bus.stored, DEF_Q);
        end
        proc_mode = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        load_quantum(1);
        for (int n = 0; n < 258; n++) begin
            run_slice(-1, 1'b1, 1, -1);
        end
        vectors++;
        if (pcnt !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate: preempt_cnt got %0d want 255", pcnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_qload();
        test_hlt();
        test_abort();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
